ball_render_slave: RTL and testbench

- Avalon-MM slave that receives ball state written by the NIOS II software over the avalon interface.
- Holds that state double-buffered and commits it at vertical sync.
- Answers the VGA pixel scan with is_ball/ballID for the color mapper.
- Also drives the 32-bit export word shown on the hex displays.

---
 rtl/ball_render_slave.sv | 206 ++++++++++++++++++++
 tb/tb_ball_render_slave.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ball_render_slave.sv
`default_nettype none
// ============================================================================
//  Module      : ball_render_slave
//  Description : Avalon-MM slave holding double-buffered ball state written by
//                software. The back buffer is committed to the front buffer on
//                the falling edge of VGA_VS when a commit is pending. A 2-stage
//                hit-test pipeline answers the pixel scan (DrawX/DrawY) with
//                is_ball/ballID. An EXPORT register drives the hex displays.
//  Ports       : Clk, Reset_n (sync, active-low)
//                avs_* : Avalon-MM slave, read latency 1, no wait states
//                VGA_VS, DrawX, DrawY : pixel scan inputs
//                is_ball, ballID      : hit result, 2 Clk after DrawX/DrawY
//                export_data          : EXPORT register contents
//  Revision    : 1.0 - initial release
// ============================================================================
module ball_render_slave #(
    parameter int NUM_BALLS = 4,
    parameter int ID_W      = 2
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              avs_chipselect,
    input  logic [3:0]        avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [3:0]        avs_byteenable,
    input  logic [31:0]       avs_writedata,
    output logic [31:0]       avs_readdata,
    input  logic              VGA_VS,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    output logic              is_ball,
    output logic [ID_W-1:0]   ballID,
    output logic [31:0]       export_data
);

    // Implemented BALLn bits: [31] enable, [25:20] radius, [19:10] y, [9:0] x
    localparam logic [31:0] c_BALL_MASK   = 32'h83FF_FFFF;
    localparam logic [3:0]  c_ADDR_CTRL   = 4'd8;
    localparam logic [3:0]  c_ADDR_STATUS = 4'd9;
    localparam logic [3:0]  c_ADDR_EXPORT = 4'd10;

    logic [31:0]          r_back  [NUM_BALLS];
    logic [31:0]          r_front [NUM_BALLS];
    logic                 r_commit_pending;
    logic [15:0]          r_frame_count;
    logic                 r_vs_q;
    logic [31:0]          r_export;
    logic [31:0]          r_readdata;
    logic                 r_is_ball;
    logic [ID_W-1:0]      r_ball_id;

    logic                 w_wr;
    logic                 w_rd;
    logic                 w_vs_fall;
    logic                 w_commit;
    logic [31:0]          w_be_mask;
    logic [31:0]          w_rdata;
    logic [NUM_BALLS-1:0] w_hit;
    logic [ID_W-1:0]      w_id;

    assign w_wr      = avs_chipselect & avs_write;
    assign w_rd      = avs_chipselect & avs_read;
    assign w_vs_fall = r_vs_q & ~VGA_VS;
    // Copy is decided by the pending flag as it stood before this edge
    assign w_commit  = w_vs_fall & r_commit_pending;
    assign w_be_mask = {{8{avs_byteenable[3]}}, {8{avs_byteenable[2]}},
                        {8{avs_byteenable[1]}}, {8{avs_byteenable[0]}}};

    // ------------------------------------------------------------------
    // Ball buffers: software writes land in back; front is refreshed
    // from the pre-write back contents on a commit edge.
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        for (int i = 0; i < NUM_BALLS; i++) begin
            if (!Reset_n) begin
                r_back[i]  <= '0;
                r_front[i] <= '0;
            end else begin
                if (w_wr && (avs_address == 4'(i))) begin
                    r_back[i] <= ((r_back[i] & ~w_be_mask) |
                                  (avs_writedata & w_be_mask)) & c_BALL_MASK;
                end
                if (w_commit) begin
                    r_front[i] <= r_back[i];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Control / status / export / read data
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_vs_q           <= 1'b1;
            r_frame_count    <= '0;
            r_commit_pending <= 1'b0;
            r_export         <= '0;
            r_readdata       <= '0;
        end else begin
            r_vs_q <= VGA_VS;
            if (w_vs_fall) begin
                r_frame_count <= r_frame_count + 16'd1;
            end
            // A commit request on a frame edge wins over the clear
            if (w_wr && (avs_address == c_ADDR_CTRL) &&
                avs_byteenable[0] && avs_writedata[0]) begin
                r_commit_pending <= 1'b1;
            end else if (w_vs_fall) begin
                r_commit_pending <= 1'b0;
            end
            if (w_wr && (avs_address == c_ADDR_EXPORT)) begin
                r_export <= (r_export & ~w_be_mask) | (avs_writedata & w_be_mask);
            end
            if (w_rd) begin
                r_readdata <= w_rdata;
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        for (int i = 0; i < NUM_BALLS; i++) begin
            if (avs_address == 4'(i)) begin
                w_rdata = r_back[i];
            end
        end
        if (avs_address == c_ADDR_STATUS) begin
            w_rdata = {r_frame_count, 15'd0, r_commit_pending};
        end
        if (avs_address == c_ADDR_EXPORT) begin
            w_rdata = r_export;
        end
    end

    // ------------------------------------------------------------------
    // Hit test stage 1 (per slot): squared distances and squared radius.
    // Distances use signed 11-bit differences so centres near the screen
    // edges never wrap around.
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NUM_BALLS; g++) begin : g_slot
        logic signed [10:0] w_dx;
        logic signed [10:0] w_dy;
        logic [9:0]         w_adx;
        logic [9:0]         w_ady;
        logic [5:0]         w_rad;
        logic               w_unused_bits;
        logic [19:0]        r_dx2;
        logic [19:0]        r_dy2;
        logic [11:0]        r_r2;
        logic               r_en;

        assign w_dx  = $signed({1'b0, DrawX}) - $signed({1'b0, r_front[g][9:0]});
        assign w_dy  = $signed({1'b0, DrawY}) - $signed({1'b0, r_front[g][19:10]});
        assign w_adx = w_dx[10] ? 10'(-w_dx) : w_dx[9:0];
        assign w_ady = w_dy[10] ? 10'(-w_dy) : w_dy[9:0];
        assign w_rad = r_front[g][25:20];
        assign w_unused_bits = ^r_front[g][30:26];

        always_ff @(posedge Clk) begin
            if (!Reset_n) begin
                r_dx2 <= '0;
                r_dy2 <= '0;
                r_r2  <= '0;
                r_en  <= 1'b0;
            end else begin
                r_dx2 <= {10'd0, w_adx} * {10'd0, w_adx};
                r_dy2 <= {10'd0, w_ady} * {10'd0, w_ady};
                r_r2  <= {6'd0, w_rad} * {6'd0, w_rad};
                r_en  <= r_front[g][31];
            end
        end

        // Stage 2 compare on a full 21-bit sum
        assign w_hit[g] = r_en &
            (({1'b0, r_dx2} + {1'b0, r_dy2}) <= {9'd0, r_r2});
    end

    // Lowest-index hit wins
    always_comb begin
        w_id = '0;
        for (int i = NUM_BALLS - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_id = ID_W'(i);
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_is_ball <= 1'b0;
            r_ball_id <= '0;
        end else begin
            r_is_ball <= |w_hit;
            r_ball_id <= w_id;
        end
    end

    assign avs_readdata = r_readdata;
    assign is_ball      = r_is_ball;
    assign ballID       = r_ball_id;
    assign export_data  = r_export;

endmodule
`default_nettype wire

// File: tb/tb_ball_render_slave.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ball_render_slave
//  Description : Self-checking bench for ball_render_slave. Reads and pixel
//                queries push expected values into queues; monitors pop and
//                compare when the DUT presents the result.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ball_render_slave;

    localparam int NUM_BALLS = 4;
    localparam int ID_W      = 2;

    logic            clk;
    logic            rst_n;
    logic            cs, rd, wr;
    logic [3:0]      addr;
    logic [3:0]      be;
    logic [31:0]     wdata;
    logic [31:0]     rdata;
    logic            vs;
    logic [9:0]      draw_x, draw_y;
    logic            is_ball;
    logic [ID_W-1:0] ball_id;
    logic [31:0]     export_data;

    ball_render_slave #(.NUM_BALLS(NUM_BALLS), .ID_W(ID_W)) u_dut (
        .Clk            (clk),
        .Reset_n        (rst_n),
        .avs_chipselect (cs),
        .avs_address    (addr),
        .avs_read       (rd),
        .avs_write      (wr),
        .avs_byteenable (be),
        .avs_writedata  (wdata),
        .avs_readdata   (rdata),
        .VGA_VS         (vs),
        .DrawX          (draw_x),
        .DrawY          (draw_y),
        .is_ball        (is_ball),
        .ballID         (ball_id),
        .export_data    (export_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_back  [NUM_BALLS];
    logic [31:0] m_front [NUM_BALLS];
    logic        m_pending;
    logic [15:0] m_frame;
    logic [31:0] m_export;

    task automatic model_reset();
        for (int i = 0; i < NUM_BALLS; i++) begin
            m_back[i]  = '0;
            m_front[i] = '0;
        end
        m_pending = 1'b0;
        m_frame   = '0;
        m_export  = '0;
    endtask

    function automatic logic [31:0] lane_mask(input logic [3:0] b);
        return {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
    endfunction

    task automatic model_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] b);
        logic [31:0] m;
        m = lane_mask(b);
        if (a < NUM_BALLS)
            m_back[a] = ((m_back[a] & ~m) | (d & m)) & 32'h83FF_FFFF;
        else if (a == 4'd8 && b[0] && d[0])
            m_pending = 1'b1;
        else if (a == 4'd10)
            m_export = (m_export & ~m) | (d & m);
    endtask

    task automatic model_vs_fall();
        m_frame = m_frame + 16'd1;
        if (m_pending) begin
            for (int i = 0; i < NUM_BALLS; i++) m_front[i] = m_back[i];
            m_pending = 1'b0;
        end
    endtask

    function automatic logic [31:0] model_read(input logic [3:0] a);
        if (a < NUM_BALLS) return m_back[a];
        if (a == 4'd9)     return {m_frame, 15'd0, m_pending};
        if (a == 4'd10)    return m_export;
        return 32'd0;
    endfunction

    // Expected {is_ball, ballID} from the front model
    function automatic logic [31:0] model_pixel(input int x, input int y);
        for (int i = 0; i < NUM_BALLS; i++) begin
            int bx, by, r, dx, dy;
            bx = int'(m_front[i][9:0]);
            by = int'(m_front[i][19:10]);
            r  = int'(m_front[i][25:20]);
            dx = x - bx;
            dy = y - by;
            if (m_front[i][31] && (dx*dx + dy*dy <= r*r))
                return 32'(4 + i);
        end
        return 32'd0;
    endfunction

    function automatic logic [31:0] ball(input int en, input int r, input int y, input int x);
        return (32'(en) << 31) | (32'(r) << 20) | (32'(y) << 10) | 32'(x);
    endfunction

    // ---------------- scoreboard ----------------
    logic [31:0] rd_q[$];
    string       rd_tag[$];
    logic [31:0] pix_q[$];
    string       pix_tag[$];
    logic        pix_chk;
    logic        rd_v, pv1, pv2;

    always @(posedge clk) begin
        rd_v <= cs & rd;
        pv1  <= pix_chk;
        pv2  <= pv1;
    end

    always @(negedge clk) begin
        if (rd_v) begin
            if (rd_q.size() == 0) check("rd_underflow", 32'd0, 32'd1);
            else check(rd_tag.pop_front(), rdata, rd_q.pop_front());
        end
        if (pv2) begin
            if (pix_q.size() == 0) check("pix_underflow", 32'd0, 32'd1);
            else check(pix_tag.pop_front(), {29'd0, is_ball, ball_id}, pix_q.pop_front());
        end
    end

    // ---------------- bus tasks ----------------
    task automatic bus_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] b);
        @(negedge clk);
        cs = 1'b1; wr = 1'b1; addr = a; wdata = d; be = b;
        model_write(a, d, b);
        @(negedge clk);
        cs = 1'b0; wr = 1'b0;
    endtask

    // Write issued in the same cycle as a VGA_VS falling edge
    task automatic bus_write_vs(input logic [3:0] a, input logic [31:0] d, input logic [3:0] b);
        @(negedge clk);
        vs = 1'b0;
        cs = 1'b1; wr = 1'b1; addr = a; wdata = d; be = b;
        model_vs_fall();
        model_write(a, d, b);
        @(negedge clk);
        cs = 1'b0; wr = 1'b0; vs = 1'b1;
    endtask

    task automatic bus_read(input string tag, input logic [3:0] a);
        @(negedge clk);
        cs = 1'b1; rd = 1'b1; addr = a;
        rd_q.push_back(model_read(a));
        rd_tag.push_back(tag);
        @(negedge clk);
        cs = 1'b0; rd = 1'b0;
    endtask

    task automatic pulse_vs();
        @(negedge clk);
        vs = 1'b0;
        model_vs_fall();
        @(negedge clk);
        vs = 1'b1;
    endtask

    task automatic commit();
        bus_write(4'd8, 32'd1, 4'hF);
        pulse_vs();
    endtask

    task automatic pixel(input string tag, input int x, input int y);
        @(negedge clk);
        draw_x = 10'(x); draw_y = 10'(y);
        pix_q.push_back(model_pixel(x, y));
        pix_tag.push_back(tag);
        pix_chk = 1'b1;
        @(negedge clk);
        pix_chk = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        cs = 0; rd = 0; wr = 0; addr = 0; be = 0; wdata = 0;
        vs = 1; draw_x = 0; draw_y = 0; pix_chk = 0;
        rst_n = 0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_readdata", rdata, 32'd0);
        check("rst_is_ball", {31'd0, is_ball}, 32'd0);
        check("rst_ballid", {30'd0, ball_id}, 32'd0);
        check("rst_export", export_data, 32'd0);
        rst_n = 1;
        bus_read("rst_status", 4'd9);

        // Write / readback, partial byte lanes
        bus_write(4'd1, 32'h8004_B0A0, 4'hF);
        bus_read("ball1_full", 4'd1);
        bus_write(4'd1, 32'h0000_00FF, 4'h1);
        bus_read("ball1_lane0", 4'd1);

        // Commit timing
        bus_write(4'd0, ball(1, 10, 100, 100), 4'hF);
        pixel("pre_commit", 105, 105);
        bus_write(4'd8, 32'd1, 4'hF);
        bus_read("status_pending", 4'd9);
        pulse_vs();
        bus_read("status_committed", 4'd9);
        pixel("post_commit", 105, 105);

        // Priority and radius boundary
        bus_write(4'd0, ball(1, 10, 50, 50), 4'hF);
        bus_write(4'd2, ball(1, 10, 50, 50), 4'hF);
        commit();
        pixel("prio_both", 50, 50);
        bus_write(4'd0, ball(0, 10, 50, 50), 4'hF);
        commit();
        pixel("prio_ball2", 50, 50);
        bus_write(4'd0, ball(1, 10, 50, 50), 4'hF);
        commit();
        pixel("edge_out_61", 61, 50);
        pixel("edge_in_60", 60, 50);

        // Screen-edge wrap
        bus_write(4'd3, ball(1, 5, 0, 0), 4'hF);
        commit();
        pixel("wrap_1020", 1020, 0);
        pixel("corner_3_4", 3, 4);
        pixel("corner_4_4", 4, 4);

        // Ball write coinciding with a commit edge
        bus_write(4'd0, ball(1, 3, 200, 200), 4'hF);
        bus_write(4'd8, 32'd1, 4'hF);
        bus_write_vs(4'd0, ball(1, 3, 400, 400), 4'hF);
        bus_read("simul_back_new", 4'd0);
        pixel("simul_front_old", 200, 200);
        pixel("simul_front_not_new", 400, 400);
        // Commit request coinciding with a frame edge stays pending
        bus_write_vs(4'd8, 32'd1, 4'hF);
        bus_read("ctrl_on_vs_status", 4'd9);
        pulse_vs();
        pixel("late_commit_new", 400, 400);
        bus_read("status_frames", 4'd9);

        // Export and unmapped addresses
        bus_write(4'd10, 32'hA500_0000, 4'hF);
        check("export_out", export_data, 32'hA500_0000);
        bus_read("export_read", 4'd10);
        bus_read("unmapped_12", 4'd12);
        bus_read("unmapped_5", 4'd5);

        // Reset discards all state
        repeat (3) @(negedge clk);
        rst_n = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst2_export", export_data, 32'd0);
        check("rst2_is_ball", {31'd0, is_ball}, 32'd0);
        rst_n = 1;
        bus_read("rst2_status", 4'd9);
        bus_read("rst2_ball1", 4'd1);

        repeat (5) @(negedge clk);
        if (rd_q.size() != 0 || pix_q.size() != 0)
            check("drain", 32'(rd_q.size() + pix_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
